// File: rtl/mult_pipeline_if.sv
// Issue, bypass-tap and write-back signals between execute/decode/write-back
// and the multiply pipeline.
interface mult_pipeline_if #(
    parameter int DATA_W = 32,
    parameter int STAGES = 5,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic                     stall_i;
    logic                     kill_i;
    logic                     valid_i;
    logic [31:0]              instr_i;
    logic [31:0]              pc_i;
    logic [DATA_W-1:0]        data_a_i;
    logic [DATA_W-1:0]        data_b_i;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic                     wr_en_i;
    logic [ADDR_W-1:0]        rd_addr_a_i;
    logic [ADDR_W-1:0]        rd_addr_b_i;
    logic [STAGES-1:0]        stage_valid_o;
    logic [STAGES*ADDR_W-1:0] stage_addr_o;
    logic [STAGES-1:0]        stage_wr_en_o;
    logic                     hazard_o;
    logic [CNT_W-1:0]         inflight_o;
    logic                     wb_valid_o;
    logic                     wb_wr_en_o;
    logic [DATA_W-1:0]        wb_data_o;
    logic [ADDR_W-1:0]        wb_addr_o;
    logic [31:0]              wb_instr_o;
    logic [31:0]              wb_pc_o;

    modport master (
        output stall_i, kill_i, valid_i, instr_i, pc_i, data_a_i, data_b_i,
               wr_addr_i, wr_en_i, rd_addr_a_i, rd_addr_b_i,
        input  stage_valid_o, stage_addr_o, stage_wr_en_o, hazard_o, inflight_o,
               wb_valid_o, wb_wr_en_o, wb_data_o, wb_addr_o, wb_instr_o, wb_pc_o
    );

    modport slave (
        input  stall_i, kill_i, valid_i, instr_i, pc_i, data_a_i, data_b_i,
               wr_addr_i, wr_en_i, rd_addr_a_i, rd_addr_b_i,
        output stage_valid_o, stage_addr_o, stage_wr_en_o, hazard_o, inflight_o,
               wb_valid_o, wb_wr_en_o, wb_data_o, wb_addr_o, wb_instr_o, wb_pc_o
    );
endinterface

// File: rtl/mult_pipeline.sv
// Parametrised RISC-V M multiply pipeline: result formed at issue, then carried
// with its tags through STAGES registers, with bypass taps and RAW hazard detect.
module mult_pipeline #(
    parameter int DATA_W = 32,
    parameter int STAGES = 5,
    parameter int ADDR_W = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mult_pipeline_if.slave bus
);
    localparam int CNT_W = $clog2(STAGES + 1);
    localparam int PW    = 2 * DATA_W;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [31:0]       instr;
        logic [31:0]       pc;
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    stage_t            issue_entry;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  inflight_d;
    logic              issue_acc;
    logic              retire;
    logic [2:0]        funct3;
    logic              a_signed;
    logic              b_signed;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] result;

    always_comb begin
        funct3   = bus.instr_i[14:12];
        a_signed = (funct3[1:0] != 2'b11);
        b_signed = ~funct3[1];
        a_ext    = {{DATA_W{a_signed & bus.data_a_i[DATA_W-1]}}, bus.data_a_i};
        b_ext    = {{DATA_W{b_signed & bus.data_b_i[DATA_W-1]}}, bus.data_b_i};
        // Truncated product of the extended operands is exact for every signedness mix.
        prod     = a_ext * b_ext;
        if (funct3[2]) begin
            result = '0;
        end else if (funct3[1:0] == 2'b00) begin
            result = prod[DATA_W-1:0];
        end else begin
            result = prod[PW-1:DATA_W];
        end
    end

    assign issue_acc = bus.valid_i & ~bus.stall_i & ~bus.kill_i;
    assign retire    = stage_q[STAGES-1].valid;

    always_comb begin
        issue_entry.valid = issue_acc;
        issue_entry.wr_en = bus.wr_en_i & ~funct3[2];
        issue_entry.addr  = bus.wr_addr_i;
        issue_entry.data  = result;
        issue_entry.instr = bus.instr_i;
        issue_entry.pc    = bus.pc_i;

        stage_d    = stage_q;
        inflight_d = inflight_q;
        if (bus.kill_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_d[k].valid = 1'b0;
            end
            inflight_d = '0;
        end else if (!bus.stall_i) begin
            stage_d[0] = issue_entry;
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (issue_acc && !retire) begin
                inflight_d = inflight_q + CNT_W'(1);
            end else if (!issue_acc && retire) begin
                inflight_d = inflight_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            inflight_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            inflight_q <= inflight_d;
        end
    end

    logic [STAGES-1:0]        valid_vec;
    logic [STAGES-1:0]        wr_en_vec;
    logic [STAGES*ADDR_W-1:0] addr_vec;
    logic [STAGES-1:0]        hz_vec;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_tap
            assign valid_vec[gi]                  = stage_q[gi].valid;
            assign wr_en_vec[gi]                  = stage_q[gi].valid & stage_q[gi].wr_en;
            assign addr_vec[gi*ADDR_W +: ADDR_W]  = stage_q[gi].addr;
            if (gi < STAGES - 1) begin : g_hz
                assign hz_vec[gi] = stage_q[gi].valid & stage_q[gi].wr_en &
                    (((stage_q[gi].addr == bus.rd_addr_a_i) && (bus.rd_addr_a_i != '0)) ||
                     ((stage_q[gi].addr == bus.rd_addr_b_i) && (bus.rd_addr_b_i != '0)));
            end else begin : g_wb
                // Decode bypasses the retiring entry from wb_data_o, so it never stalls.
                assign hz_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.stage_valid_o = valid_vec;
    assign bus.stage_wr_en_o = wr_en_vec;
    assign bus.stage_addr_o  = addr_vec;
    assign bus.hazard_o      = |hz_vec;
    assign bus.inflight_o    = inflight_q;
    assign bus.wb_valid_o    = stage_q[STAGES-1].valid;
    assign bus.wb_wr_en_o    = stage_q[STAGES-1].valid & stage_q[STAGES-1].wr_en;
    assign bus.wb_data_o     = stage_q[STAGES-1].data;
    assign bus.wb_addr_o     = stage_q[STAGES-1].addr;
    assign bus.wb_instr_o    = stage_q[STAGES-1].instr;
    assign bus.wb_pc_o       = stage_q[STAGES-1].pc;
endmodule

// File: doc/mult_pipeline.md
# mult_pipeline

Parametrised integer multiply pipeline replacing the fixed five-latch exe→mult1…mult5 chain. Accepts one multiply per cycle from the execute stage, carries instruction, PC, destination register and write enable through `STAGES` registered stages, and presents the result to the write-back arbiter. Each stage exposes bypass taps and a RAW-hazard flag for decode. The pipeline supports global stall, full flush (kill) and the four RISC-V M multiply modes.

## Interface
- `DATA_W`, 32: operand and result width.
- `STAGES`, 5: pipeline depth; legal range 2..8.
- `ADDR_W`, 5: register-address width.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset. One clock; reset is synchronous and active-high.
- `stall_i`  in  1: freeze all stages.
- `kill_i`  in  1: invalidate every in-flight entry.
- `valid_i`  in  1: issue request from execute.
- `instr_i`  in  32: instruction; funct3 = `instr_i[14:12]`.
- `pc_i`  in  32: instruction PC.
- `data_a_i`, `data_b_i`  in  DATA_W: rs1 and rs2 operands.
- `wr_addr_i`  in  ADDR_W: destination register.
- `wr_en_i`  in  1: destination write enable.
- `rd_addr_a_i`, `rd_addr_b_i`  in  ADDR_W: decode source registers, used for the hazard check.
- `stage_valid_o`  out  STAGES: per-stage valid, bit k-1 = stage k.
- `stage_addr_o`  out  STAGES*ADDR_W: per-stage destination, flattened, stage 1 in the LSBs.
- `stage_wr_en_o`  out  STAGES: per-stage write enable, qualified by valid.
- `hazard_o`  out  1: decode must stall.
- `inflight_o`  out  $clog2(STAGES+1): number of valid stages.
- `wb_valid_o`, `wb_wr_en_o`  out  1: stage-STAGES valid and write enable.
- `wb_data_o`  out  DATA_W: result.
- `wb_addr_o`  out  ADDR_W: destination register.
- `wb_instr_o`, `wb_pc_o`  out  32: instruction and PC of the retiring entry.

## Operation
- Issue accepted when `valid_i & ~stall_i & ~kill_i`. The entry is written into stage 1.
- The full product (2*DATA_W bits) is formed at issue from the funct3 mode, then shifted down the stages unchanged:
  - 000 MUL: low DATA_W bits, signed×signed.
  - 001 MULH: high bits, signed×signed.
  - 010 MULHSU: high bits, signed a × unsigned b.
  - 011 MULHU: high bits, unsigned×unsigned.
  - funct3[2]=1: result 0, `wr_en` forced 0. The entry still flows and counts as in flight.
- Each cycle without stall or kill, stage k+1 takes stage k. Stage 1 takes the issue or becomes invalid.
- `stall_i`: every stage register and `inflight_o` hold. Outputs are unchanged.
- `kill_i`: all stage valids clear next cycle and `inflight_o` becomes 0. Kill has priority over stall and issue. Data, addr, instr and pc registers are don't-care after kill.
- `hazard_o` = OR over stages 1..STAGES-1 of (valid & wr_en & addr == rd_addr_x & rd_addr_x ≠ 0), for x in {a, b}. Stage STAGES is excluded because decode bypasses from `wb_data_o`.
- `inflight_o` is a registered counter, not a popcount:
  - +1 on accepted issue.
  - −1 when stage STAGES is valid and not stalled.
  - Both in the same cycle: unchanged.
  - Must always equal popcount(`stage_valid_o`).
- `stage_wr_en_o` and `wb_wr_en_o` are 0 whenever the corresponding valid is 0.

## Timing
- Reset: all valids 0, `inflight_o` 0, `hazard_o` 0. All data, addr, instr and pc outputs 0.
- Latency: an issue in cycle T gives `wb_valid_o` = 1 during cycle T+STAGES, assuming no stalls. Each stall cycle adds 1.
- Throughput: one issue per non-stalled cycle.
- `wb_valid_o` is high for exactly one cycle per entry unless stalled. While stalled it stays high with stable data.
- `hazard_o` is combinational from the registered stages and the `rd_addr` inputs. It is valid in the same cycle.
- Reset asserted mid-operation: all entries dropped next edge. Reset has priority over kill and stall.
- Issue in the same cycle as kill: the issue is discarded. Issue in the same cycle as stall: the issue is not accepted and execute must hold it.

## Test plan
- MUL, a=7, b=−3, wr_addr=5, issue at T → at T+5: `wb_data_o`=0xFFFFFFEB, `wb_addr_o`=5, `wb_valid_o`=1 for one cycle.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- Back-to-back issues on 5 consecutive cycles → `inflight_o` steps 1..5. Results retire in order on 5 consecutive cycles. Counter returns to 0.
- Issue writing r3, then `rd_addr_a_i`=3 → `hazard_o`=1 while the entry is in stages 1..4, 0 when it reaches stage 5. `rd_addr_a_i`=0 → `hazard_o` never set.
- 3 entries in flight, `stall_i` for 4 cycles → all outputs frozen and `wb_valid_o` held. After release, retire timing is shifted by exactly 4 cycles.
- 4 entries in flight, `kill_i` with a simultaneous issue → next cycle all valids 0, `inflight_o`=0, no `wb_valid_o` ever appears. Repeat with `rst_i` and check identical results. Re-run with `STAGES`=2 and 8 and check latency = `STAGES`.
